// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter that snoops the core's data-memory
// store path. Bytes stored to TXDATA are queued in a small FIFO and sent
// LSB first on tx. STATUS reports {overflow, full, empty, busy}.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   MemWrite   core store strobe (same cycle as DataAdr/WriteData)
//   DataAdr    core data address
//   WriteData  core store data
//   ReadData   register read data, combinational from DataAdr
//   tx         serial line, idle high, always driven from a register
//   busy       high while bytes are queued or a frame is in flight
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bitIdx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic       w_hit;
    logic       w_wrTxData;
    logic       w_wrStatus;
    logic       w_full;
    logic       w_empty;
    logic       w_baudDone;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [7:0] w_head;
    logic       w_unused;

    // Address decode: 8-byte window, DataAdr[2] picks STATUS over TXDATA.
    assign w_hit      = (DataAdr[31:3] == BASE_ADDR[31:3]);
    assign w_wrTxData = MemWrite && w_hit && !DataAdr[2];
    assign w_wrStatus = MemWrite && w_hit && DataAdr[2];

    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_baudDone = (r_baud == BAUD_LAST);
    assign w_head     = r_mem[r_rdPtr];

    // The FSM takes the head byte when idle, or at the last stop-bit cycle
    // so that queued frames follow each other with no idle gap.
    assign w_pop  = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baudDone));

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign w_push = w_wrTxData && (!w_full || w_pop);
    assign w_drop = w_wrTxData && w_full && !w_pop;

    assign busy     = (r_state != IDLE) || !w_empty;
    assign tx       = r_tx;
    assign ReadData = (w_hit && DataAdr[2]) ? {28'b0, r_overflow, w_full, w_empty, busy} : 32'b0;

    // Address byte-offset bits and upper store data are don't-cares.
    assign w_unused = ^{DataAdr[1:0], WriteData[31:8]};

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= WriteData[7:0];
        end
    end

    // Sticky overflow flag; a drop on the same edge as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_wrStatus && WriteData[3]) begin
            r_overflow <= 1'b0;
        end
    end

    // Transmit FSM. tx is loaded with the level of the state being entered,
    // so the line changes on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baudDone) begin
                        r_baud   <= '0;
                        r_bitIdx <= '0;
                        r_tx     <= r_shift[0];
                        r_state  <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baudDone) begin
                        r_baud <= '0;
                        if (r_bitIdx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baudDone) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
// Self-checking bench for mmio_uart_tx. A reference model keeps the list of
// accepted bytes with their push edge and frame start edge, and derives the
// expected line level, busy and STATUS from those times. An independent line
// decoder recovers bytes from tx for the hand-written sequences.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam int          C     = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * C;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        MemWrite  = 1'b0;
    logic [31:0] DataAdr   = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;

    mmio_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: every accepted byte with the edge it was stored on
    // and the edge its start bit begins.
    typedef struct {
        logic [7:0] b;
        int         pushT;
        int         startT;
    } frame_t;

    frame_t mq[$];
    int     lastStart = -1000;
    logic   mOvf      = 1'b0;
    int     edgeN     = 0;

    // Line decoder state
    logic       decActive = 1'b0;
    int         decStart  = 0;
    int         decK      = 0;
    logic [7:0] decByte   = 8'h0;
    logic [7:0] decBytes[$];
    int         decStarts[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edgeN, act, exp);
        end
    endtask

    // Bytes still sitting in the FIFO after edge t
    function automatic int pendingAfter(input int t);
        int n = 0;
        foreach (mq[i]) begin
            if (mq[i].pushT <= t && mq[i].startT > t) n++;
        end
        return n;
    endfunction

    function automatic logic expTx(input int t);
        foreach (mq[i]) begin
            if (t >= mq[i].startT && t < mq[i].startT + FRAME) begin
                int k = (t - mq[i].startT) / C;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return mq[i].b[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic expBusy(input int t);
        foreach (mq[i]) begin
            if (mq[i].pushT <= t && t < mq[i].startT + FRAME) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] adr);
        int n;
        if (adr[31:3] != BASE[31:3] || !adr[2]) return 32'h0;
        n = pendingAfter(edgeN);
        return {28'b0, mOvf, (n == DEPTH), (n == 0), expBusy(edgeN)};
    endfunction

    // Apply the bus inputs seen at edge t to the model
    task automatic modelEdge(input int t);
        logic hit;
        int   st;
        if (reset) begin
            mq.delete();
            lastStart = -1000;
            mOvf      = 1'b0;
        end else begin
            hit = (DataAdr[31:3] == BASE[31:3]);
            if (MemWrite && hit && !DataAdr[2]) begin
                if (pendingAfter(t) < DEPTH) begin
                    st = (t + 1 > lastStart + FRAME) ? t + 1 : lastStart + FRAME;
                    mq.push_back('{WriteData[7:0], t, st});
                    lastStart = st;
                end else begin
                    mOvf = 1'b1;
                end
            end else if (MemWrite && hit && DataAdr[2] && WriteData[3]) begin
                mOvf = 1'b0;
            end
            while (mq.size() > 0 && mq[0].startT + FRAME <= t) void'(mq.pop_front());
        end
    endtask

    // Per-edge model update, line/busy comparison and line decoding
    always @(posedge clk) begin
        edgeN++;
        modelEdge(edgeN);
        #1;
        checkOutput("tx", 32'(tx), 32'(expTx(edgeN)));
        checkOutput("busy", 32'(busy), 32'(expBusy(edgeN)));
        if (reset) begin
            decActive = 1'b0;
        end else if (!decActive) begin
            if (tx == 1'b0) begin
                decActive = 1'b1;
                decStart  = edgeN;
            end
        end else begin
            decK = edgeN - decStart;
            if ((decK % C) == C / 2 && decK / C >= 1 && decK / C <= 8) decByte[decK/C-1] = tx;
            if (decK == 9 * C + C / 2) begin
                decBytes.push_back(decByte);
                decStarts.push_back(decStart);
                decActive = 1'b0;
            end
        end
    end

    // Drive one bus cycle at the falling edge and check ReadData against the model
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] data);
        @(negedge clk);
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = data;
        #1;
        checkOutput("ReadData", ReadData, expRead(adr));
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 32'h0, 32'h0);
    endtask

    task automatic waitUntilEdge(input int target);
        int guard = 0;
        while (edgeN < target && guard < 20000) begin
            idleCycles(1);
            guard++;
        end
        checkOutput("waitBound", 32'(edgeN >= target), 32'h1);
    endtask

    task automatic clearDecoder();
        decBytes.delete();
        decStarts.delete();
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;
        logic [31:0] expRd;
        logic        expBusy;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        int          e;
        int          r;
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;

        vecs[0] = '{1'b0, 32'h0000_1004, 32'h0000_0000, 32'h2, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0FFC, 32'hFFFF_FF55, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_1008, 32'h0000_0055, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_1000, 32'h0000_0055, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_1007, 32'h0000_0000, 32'h2, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 32'h2, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_1800, 32'h0000_00AA, 32'h0, 1'b0};
        vecs[7] = '{1'b0, 32'h8000_1004, 32'h0000_0000, 32'h0, 1'b0};

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        reset = 1'b0;
        DataAdr = 32'h1004;
        #1;
        checkOutput("resetTx", 32'(tx), 32'h1);
        checkOutput("resetBusy", 32'(busy), 32'h0);
        checkOutput("resetStatus", ReadData, 32'h2);

        // Decode table
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].data);
            checkOutput("vecRead", ReadData, vecs[i].expRd);
            @(posedge clk);
            #1;
            checkOutput("vecBusy", 32'(busy), 32'(vecs[i].expBusy));
            checkOutput("vecTx", 32'(tx), 32'h1);
        end
        idleCycles(2);

        // Single byte
        clearDecoder();
        applyStimulus(1'b1, 32'h1000, 32'hFFFF_FF55);
        e = edgeN + 1;
        applyStimulus(1'b0, 32'h1004, 32'h0);
        checkOutput("pushStatus", ReadData, 32'h1);
        checkOutput("preStartTx", 32'(tx), 32'h1);
        waitUntilEdge(e + 1);
        checkOutput("startBit", 32'(tx), 32'h0);
        waitUntilEdge(e + 40);
        checkOutput("busyAt40", 32'(busy), 32'h1);
        waitUntilEdge(e + 41);
        checkOutput("busyAt41", 32'(busy), 32'h0);
        checkOutput("singleCount", 32'(decBytes.size()), 32'h1);
        if (decBytes.size() >= 1) begin
            checkOutput("singleByte", 32'(decBytes[0]), 32'h55);
            checkOutput("singleStart", 32'(decStarts[0]), 32'(e + 1));
        end
        idleCycles(3);

        // Back-to-back frames
        clearDecoder();
        applyStimulus(1'b1, 32'h1000, 32'h01);
        e = edgeN + 1;
        applyStimulus(1'b1, 32'h1000, 32'h80);
        waitUntilEdge(e + 2 * FRAME + 4);
        checkOutput("b2bCount", 32'(decBytes.size()), 32'h2);
        if (decBytes.size() >= 2) begin
            checkOutput("b2bByte0", 32'(decBytes[0]), 32'h01);
            checkOutput("b2bByte1", 32'(decBytes[1]), 32'h80);
            checkOutput("b2bGap", 32'(decStarts[1] - decStarts[0]), 32'd40);
        end
        idleCycles(3);

        // Overflow: six stores back to back, the sixth is dropped
        clearDecoder();
        e = edgeN + 1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h1000, 32'(8'hA0 + i));
        applyStimulus(1'b0, 32'h1004, 32'h0);
        checkOutput("ovfStatus", ReadData, 32'hD);
        applyStimulus(1'b1, 32'h1004, 32'h8);
        applyStimulus(1'b0, 32'h1004, 32'h0);
        checkOutput("ovfCleared", ReadData, 32'h5);
        waitUntilEdge(e + 5 * FRAME + 6);
        checkOutput("ovfCount", 32'(decBytes.size()), 32'h5);
        for (int i = 0; i < 5 && i < decBytes.size(); i++)
            checkOutput("ovfByte", 32'(decBytes[i]), 32'(8'hA0 + i));
        idleCycles(3);

        // Full FIFO plus a store on the STOP-to-START pop edge
        clearDecoder();
        e = edgeN + 1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h1000, 32'(8'hB0 + i));
        waitUntilEdge(e + 39);
        applyStimulus(1'b0, 32'h1004, 32'h0);
        checkOutput("fullBeforePop", ReadData, 32'h5);
        applyStimulus(1'b1, 32'h1000, 32'hB5);
        applyStimulus(1'b0, 32'h1004, 32'h0);
        checkOutput("fullAfterPop", ReadData, 32'h5);
        waitUntilEdge(e + 6 * FRAME + 4);
        checkOutput("fullCount", 32'(decBytes.size()), 32'h6);
        for (int i = 0; i < 6 && i < decBytes.size(); i++)
            checkOutput("fullByte", 32'(decBytes[i]), 32'(8'hB0 + i));
        if (decStarts.size() >= 6)
            checkOutput("fullSpan", 32'(decStarts[5] - decStarts[0]), 32'(5 * FRAME));
        idleCycles(3);

        // Reset asserted in the middle of the data bits
        clearDecoder();
        applyStimulus(1'b1, 32'h1000, 32'h00);
        e = edgeN + 1;
        applyStimulus(1'b1, 32'h1000, 32'h3C);
        waitUntilEdge(e + 10);
        checkOutput("preResetTx", 32'(tx), 32'h0);
        @(negedge clk);
        reset    = 1'b1;
        MemWrite = 1'b0;
        #1;
        checkOutput("asyncResetTx", 32'(tx), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h1004, 32'h0);
        checkOutput("postResetStatus", ReadData, 32'h2);
        idleCycles(2 * FRAME);
        checkOutput("postResetBytes", 32'(decBytes.size()), 32'h0);

        // Randomized bus traffic in phases of different store density
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       adr = 32'h1000 | 32'($urandom_range(0, 3));
            else if (r < 7)  adr = 32'h1004;
            else if (r == 7) adr = $urandom;
            else             adr = 32'h1008;
            case ((i / 250) % 3)
                0:       we = ($urandom_range(0, 1) == 0);
                1:       we = ($urandom_range(0, 19) == 0);
                default: we = ($urandom_range(0, 99) == 0);
            endcase
            data = $urandom;
            applyStimulus(we, adr, data);
        end
        idleCycles((DEPTH + 1) * FRAME + 10);
        checkOutput("drainBusy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
